// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass, pending scoreboard and clear sweep
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rd_addr  [NRD*AW]            packed read addresses, port k at [k*AW +: AW]
//   rd_data  [NRD*XLEN]          packed combinational read data
//   rd_pend  [NRD]               pending-write flag per read port
//   wr0_en/addr/data             write port 0 (low priority)
//   wr1_en/addr/data             write port 1 (high priority)
//   claim_en/claim_addr          mark a register as awaiting an in-flight producer
//   init_busy                    high during reset and the clear sweep

module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_pend,
  input  logic                  wr0_en,
  input  logic [AW-1:0]         wr0_addr,
  input  logic [XLEN-1:0]       wr0_data,
  input  logic                  wr1_en,
  input  logic [AW-1:0]         wr1_addr,
  input  logic [XLEN-1:0]       wr1_data,
  input  logic                  claim_en,
  input  logic [AW-1:0]         claim_addr,
  output logic                  init_busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     idx, idx_nxt;
  logic [XLEN-1:0]   mem [NREGS];
  logic [NREGS-1:0]  pend, pend_nxt;
  logic              busy;
  logic              wr0_ok, wr1_ok, claim_ok;

  // Reset is folded in so outputs read as "busy, zero" from the very cycle
  // rst rises, even before the state register has been reloaded.
  assign busy      = rst || (state == S_INIT);
  assign init_busy = busy;

  assign wr0_ok   = !busy && wr0_en   && !(ZERO_REG && (wr0_addr   == '0));
  assign wr1_ok   = !busy && wr1_en   && !(ZERO_REG && (wr1_addr   == '0));
  assign claim_ok = !busy && claim_en && !(ZERO_REG && (claim_addr == '0));

  // Sweep FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_INIT: begin
        idx_nxt = idx + 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        state_nxt = S_RUN;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  // Storage: the sweep owns the array during INIT; in RUN port 1 is
  // assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) begin
        mem[idx] <= '0;
      end else begin
        if (wr0_ok) mem[wr0_addr] <= wr0_data;
        if (wr1_ok) mem[wr1_addr] <= wr1_data;
      end
    end
  end

  // Scoreboard: a claim is applied after the write clears so a new
  // producer supersedes a retiring one on the same register.
  always_comb begin
    pend_nxt = pend;
    if (wr0_ok)   pend_nxt[wr0_addr]   = 1'b0;
    if (wr1_ok)   pend_nxt[wr1_addr]   = 1'b0;
    if (claim_ok) pend_nxt[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  // Read ports
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            p;

    assign a = rd_addr[k*AW +: AW];

    always_comb begin
      d = '0;
      p = 1'b0;
      if (busy) begin
        d = '0;
        p = 1'b0;
      end else if (ZERO_REG && (a == '0)) begin
        d = '0;
        p = 1'b0;
      end else if (BYPASS && wr1_en && (wr1_addr == a)) begin
        d = wr1_data;
        p = 1'b0;
      end else if (BYPASS && wr0_en && (wr0_addr == a)) begin
        d = wr0_data;
        p = 1'b0;
      end else begin
        d = mem[a];
        p = pend[a];
      end
    end

    assign rd_data[k*XLEN +: XLEN] = d;
    assign rd_pend[k]              = p;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp

module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [3:0][AW-1:0]   ra;
  logic [1:0][AW-1:0]   rb;
  logic [4*XLEN-1:0]    rd_data;
  logic [3:0]           rd_pend;
  logic [2*XLEN-1:0]    nb_data;
  logic [1:0]           nb_pend;
  logic                 wr0_en, wr1_en, claim_en;
  logic [AW-1:0]        wr0_addr, wr1_addr, claim_addr;
  logic [XLEN-1:0]      wr0_data, wr1_data;
  logic                 init_busy, nb_busy;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .rd_addr(ra), .rd_data(rd_data), .rd_pend(rd_pend),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .init_busy(init_busy)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .rd_addr(rb), .rd_data(nb_data), .rd_pend(nb_pend),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .init_busy(nb_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural register contents and pending flags
  logic [XLEN-1:0] m_mem  [NREGS];
  logic            m_pend [NREGS];
  bit              m_run = 1'b0;

  task automatic m_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic logic [XLEN-1:0] m_rdata(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && wr1_en && wr1_addr == a) return wr1_data;
    if (byp && wr0_en && wr0_addr == a) return wr0_data;
    return m_mem[a];
  endfunction

  function automatic logic m_rpend(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && wr1_en && wr1_addr == a) return 1'b0;
    if (byp && wr0_en && wr0_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic m_update();
    if (!m_run) return;
    if (wr0_en && wr0_addr != 0) begin m_mem[wr0_addr] = wr0_data; m_pend[wr0_addr] = 1'b0; end
    if (wr1_en && wr1_addr != 0) begin m_mem[wr1_addr] = wr1_data; m_pend[wr1_addr] = 1'b0; end
    if (claim_en && claim_addr != 0) m_pend[claim_addr] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    claim_en = 0; claim_addr = '0;
  endtask

  task automatic check_model();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("byp_data[%0d] a=%0d", k, ra[k]), rd_data[k*XLEN +: XLEN], m_rdata(ra[k], 1'b1));
      chk($sformatf("byp_pend[%0d] a=%0d", k, ra[k]), 32'(rd_pend[k]), 32'(m_rpend(ra[k], 1'b1)));
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("nb_data[%0d] a=%0d", k, rb[k]), nb_data[k*XLEN +: XLEN], m_rdata(rb[k], 1'b0));
      chk($sformatf("nb_pend[%0d] a=%0d", k, rb[k]), 32'(nb_pend[k]), 32'(m_rpend(rb[k], 1'b0)));
    end
  endtask

  // Counts init_busy cycles after rst release; optional probing of INIT behaviour
  task automatic run_init(input bit probe);
    int cnt;
    bit done;
    cnt  = 0;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (init_busy) begin
        cnt++;
        if (probe && cnt == 1) begin
          for (int k = 0; k < 4; k++) begin
            chk($sformatf("init_rd_data[%0d]", k), rd_data[k*XLEN +: XLEN], 32'h0);
            chk($sformatf("init_rd_pend[%0d]", k), 32'(rd_pend[k]), 32'h0);
          end
        end
        if (probe && cnt == 5) idle();
        @(posedge clk);
        #1;
      end else begin
        done = 1;
      end
    end
    chk("init_busy_cycles", cnt, 32);
    chk("nb_init_done", 32'(nb_busy), 32'h0);
    @(posedge clk);
    #1;
    m_clear();
    m_run = 1'b1;
  endtask

  typedef struct {
    logic               w0e;
    logic [AW-1:0]      w0a;
    logic [XLEN-1:0]    w0d;
    logic               w1e;
    logic [AW-1:0]      w1a;
    logic [XLEN-1:0]    w1d;
    logic               ce;
    logic [AW-1:0]      ca;
    logic [3:0][AW-1:0] ra;
    logic [3:0][31:0]   ed;
    logic [3:0]         ep;
  } vec_t;

  function automatic vec_t mk(input logic w0e, input logic [AW-1:0] w0a, input logic [31:0] w0d,
                              input logic w1e, input logic [AW-1:0] w1a, input logic [31:0] w1d,
                              input logic ce, input logic [AW-1:0] ca,
                              input logic [4*AW-1:0] a, input logic [127:0] d, input logic [3:0] p);
    vec_t v;
    v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
    v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
    v.ce = ce; v.ca = ca;
    v.ra = a; v.ed = d; v.ep = p;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Ports listed 3..0 in the address/data concatenations
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, {5'd1, 5'd0, 5'd5, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF}, 4'b0000);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, {5'd1, 5'd0, 5'd5, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF}, 4'b0000);
    tbl[2]  = mk(1, 7, 32'h1111, 1, 7, 32'h2222, 0, 0, {5'd0, 5'd5, 5'd7, 5'd7}, {32'h0, 32'hDEADBEEF, 32'h2222, 32'h2222}, 4'b0000);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 1, 3, {5'd0, 5'd0, 5'd3, 5'd7}, {32'h0, 32'h0, 32'h0, 32'h2222}, 4'b0000);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd3, 5'd3}, {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0011);
    tbl[5]  = tbl[4];
    tbl[6]  = tbl[4];
    tbl[7]  = mk(1, 3, 32'h33, 0, 0, 0, 1, 3, {5'd0, 5'd0, 5'd3, 5'd3}, {32'h0, 32'h0, 32'h33, 32'h33}, 4'b0000);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd3, 5'd3}, {32'h0, 32'h0, 32'h33, 32'h33}, 4'b0011);
    tbl[9]  = mk(0, 0, 0, 1, 3, 32'h44, 0, 0, {5'd0, 5'd0, 5'd3, 5'd3}, {32'h0, 32'h0, 32'h44, 32'h44}, 4'b0000);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd3, 5'd3}, {32'h0, 32'h0, 32'h44, 32'h44}, 4'b0000);
    tbl[11] = mk(1, 0, 32'hFFFF, 0, 0, 0, 1, 0, {5'd0, 5'd0, 5'd0, 5'd0}, 128'h0, 4'b0000);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd0}, 128'h0, 4'b0000);
    tbl[13] = mk(1, 9, 32'hA5, 1, 31, 32'h5A, 0, 0, {5'd31, 5'd9, 5'd0, 5'd9}, {32'h5A, 32'hA5, 32'h0, 32'hA5}, 4'b0000);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, {5'd31, 5'd9, 5'd0, 5'd9}, {32'h5A, 32'hA5, 32'h0, 32'hA5}, 4'b0000);
    tbl[15] = mk(1, 9, 32'h77, 1, 0, 32'h1234, 0, 0, {5'd9, 5'd0, 5'd0, 5'd0}, {32'h77, 32'h0, 32'h0, 32'h0}, 4'b0000);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, {5'd9, 5'd31, 5'd0, 5'd0}, {32'h77, 32'h5A, 32'h0, 32'h0}, 4'b0000);

    // Reset state, with a write present that must not leak through
    idle();
    rst = 1'b1;
    ra  = {5'd1, 5'd2, 5'd3, 5'd4};
    rb  = {5'd1, 5'd2};
    repeat (3) tick();
    wr1_en = 1; wr1_addr = 5'd1; wr1_data = 32'hFFFF;
    @(negedge clk);
    chk("rst_init_busy", 32'(init_busy), 32'h1);
    chk("rst_rd_data", rd_data[127:96], 32'h0);
    chk("rst_rd_pend", 32'(rd_pend), 32'h0);
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_init(1'b0);

    // Every entry cleared by the sweep
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) ra[k] = AW'(4*i + k);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("swept_data x%0d", 4*i + k), rd_data[k*XLEN +: XLEN], 32'h0);
        chk($sformatf("swept_pend x%0d", 4*i + k), 32'(rd_pend[k]), 32'h0);
      end
      tick();
    end

    // Directed vectors
    for (int i = 0; i < 17; i++) begin
      wr0_en = tbl[i].w0e; wr0_addr = tbl[i].w0a; wr0_data = tbl[i].w0d;
      wr1_en = tbl[i].w1e; wr1_addr = tbl[i].w1a; wr1_data = tbl[i].w1d;
      claim_en = tbl[i].ce; claim_addr = tbl[i].ca;
      ra = tbl[i].ra;
      rb = {tbl[i].ra[1], tbl[i].ra[0]};
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("vec%0d_data[%0d]", i, k), rd_data[k*XLEN +: XLEN], tbl[i].ed[k]);
        chk($sformatf("vec%0d_pend[%0d]", i, k), 32'(rd_pend[k]), 32'(tbl[i].ep[k]));
      end
      check_model();
      tick();
    end
    idle();

    // No-bypass instance: old value this cycle, new value next cycle
    rb = {5'd7, 5'd5};
    wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'h0BADF00D;
    @(negedge clk);
    chk("nb_same_cycle x5", nb_data[31:0], 32'hDEADBEEF);
    chk("nb_prio x7", nb_data[63:32], 32'h2222);
    tick();
    idle();
    @(negedge clk);
    chk("nb_next_cycle x5", nb_data[31:0], 32'h0BADF00D);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      wr0_en   = 1'($urandom_range(0, 1));
      wr0_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      wr0_data = $urandom;
      wr1_en   = 1'($urandom_range(0, 1));
      wr1_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      wr1_data = $urandom;
      claim_en   = 1'($urandom_range(0, 1));
      claim_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      for (int k = 0; k < 4; k++) ra[k] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      for (int k = 0; k < 2; k++) rb[k] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      @(negedge clk);
      check_model();
      tick();
    end
    idle();

    // Mid-RUN reset clears pending bits; mid-sweep reset restarts the sweep
    claim_en = 1; claim_addr = 5'd12;
    tick();
    idle();
    ra[0] = 5'd12;
    @(negedge clk);
    chk("claim_x12_pend", 32'(rd_pend[0]), 32'h1);
    m_run = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr0_en = 1; wr0_addr = 5'd4; wr0_data = 32'hFF;
    wr1_en = 1; wr1_addr = 5'd6; wr1_data = 32'h1;
    claim_en = 1; claim_addr = 5'd4;
    ra = {5'd6, 5'd6, 5'd6, 5'd6};
    run_init(1'b1);
    ra = {5'd12, 5'd6, 5'd4, 5'd12};
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("post_reset_data[%0d] a=%0d", k, ra[k]), rd_data[k*XLEN +: XLEN], 32'h0);
      chk($sformatf("post_reset_pend[%0d] a=%0d", k, ra[k]), 32'(rd_pend[k]), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RV100 pipeline: configurable width, depth and read-port count, two prioritised write ports, same-cycle write-to-read bypass, and a per-register pending-write scoreboard. It sits in the ID stage, with read ports feeding operand fetch and write ports driven by WB and a second retire path. Reset does not clear the array in one cycle; a sweep state machine zeroes one entry per cycle and reports `init_busy` until it finishes.

## Interface
- `XLEN`, 32: data width.
- `NREGS`, 32: register count, power of two ≥ 2; `AW = $clog2(NREGS)`.
- `NRD`, 2: number of read ports, ≥ 1.
- `ZERO_REG`, 1: when 1, entry 0 is hardwired to zero.
- `BYPASS`, 1: when 1, same-cycle write data is forwarded to the read ports.

- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rd_addr` in `NRD*AW`: packed read addresses; port k occupies `[k*AW +: AW]`.
- `rd_data` out `NRD*XLEN`: packed read data, combinational.
- `rd_pend` out `NRD`: pending-write flag per read port, combinational.
- `wr0_en`, `wr0_addr[AW]`, `wr0_data[XLEN]` in: write port 0, low priority.
- `wr1_en`, `wr1_addr[AW]`, `wr1_data[XLEN]` in: write port 1, high priority.
- `claim_en`, `claim_addr[AW]` in: marks a register as having an in-flight producer.
- `init_busy` out 1: high while the clear sweep runs.

## Operation
- FSM states are INIT and RUN.
  - While `rst` is high: next state is INIT, sweep index `idx` loads 0, and all pending bits clear.
  - INIT: each cycle writes 0 to `mem[idx]` and increments `idx`. When `idx == NREGS-1`, the final entry is written and the next state is RUN.
  - RUN: normal operation. There is no exit from RUN except through `rst`.
- In INIT:
  - `wr0_en`, `wr1_en` and `claim_en` are ignored.
  - `rd_data` is forced to 0 and `rd_pend` to 0.
- Writes in RUN:
  - A write port with `en` high writes `mem[addr]` at the clock edge.
  - If both ports target the same address, port 1 wins.
  - With `ZERO_REG=1`, writes to address 0 are dropped.
- Scoreboard in RUN:
  - `claim_en` sets `pend[claim_addr]`.
  - An accepted write on either port clears `pend[addr]`.
  - If a claim and a write hit the same address in the same cycle, the claim wins and the bit ends set, because the new producer supersedes the old one.
  - Claims to address 0 are ignored when `ZERO_REG=1`.
- Read port k, in RUN, uses this priority:
  1. `ZERO_REG` and address 0: data 0, pend 0.
  2. `BYPASS`, `wr1_en` and `wr1_addr` matches: `wr1_data`, pend 0.
  3. `BYPASS`, `wr0_en` and `wr0_addr` matches: `wr0_data`, pend 0.
  4. Otherwise: `mem[addr]` and `pend[addr]`.
- A same-cycle claim does not affect `rd_pend` until the next cycle.
- With `BYPASS=0`, reads return the array contents only; write data is visible from the next cycle.
- All addresses are in range because `NREGS` is a power of two. Every read port is independent, and any number of ports may read the same address.

## Timing
- Read path is combinational from `rd_addr` and the write inputs to `rd_data` and `rd_pend`. There is no read latency.
- Write latency is 1 cycle: data appears in `mem` after the edge, and in `rd_data` the same cycle when bypassed.
- Init sweep:
  - Takes exactly `NREGS` cycles after the first clock edge with `rst` low.
  - `init_busy` is 1 while `rst` is high and throughout INIT.
  - `init_busy` falls at the edge that completes the sweep; the first RUN cycle accepts writes.
- Reset values: `init_busy`=1, `rd_data`=0, `rd_pend`=0, all pending bits 0. Array contents are defined only after the sweep.
- Reset asserted mid-sweep or mid-RUN restarts the sweep from `idx`=0 and clears all pending bits at that edge.

## Test plan
- Reset then release with `NREGS`=32: `init_busy` is high for exactly 32 cycles, and reading every address afterwards returns 0 with pend 0.
- In RUN, write x5=0xDEADBEEF on wr0 while reading x5: with `BYPASS=1`, `rd_data` is 0xDEADBEEF the same cycle. With `BYPASS=0` it reads the old value that cycle and 0xDEADBEEF the next cycle.
- wr0 writes x7=0x1111 and wr1 writes x7=0x2222 in the same cycle: bypass returns 0x2222, and a read next cycle returns 0x2222.
- Claim x3 in cycle n: `rd_pend` for x3 is 1 from cycle n+1. Write x3 in cycle n+4 and claim x3 again in the same cycle: pend stays 1. A write to x3 in n+6 with no claim gives pend 0 at n+7.
- Write x0=0xFFFF and claim x0: reads return 0 with pend 0. Then pulse `rst` at sweep `idx`=10: the sweep restarts and `init_busy` is high for 32 more cycles.
- `NRD`=4, all four ports read x9, x0, x9 and x31 after writing x9=0xA5 and x31=0x5A: `rd_data` is {0x5A, 0xA5, 0, 0xA5}, listed from port 3 down to port 0.
